// File: rtl/rob_nway_pkg.sv
// rtl/rob_nway_pkg.sv - shared widths and the lane-slice helper for the n-way reorder buffer
package rob_nway_pkg;
  localparam int RRF_SEL  = 6;
  localparam int ROB_SEL  = RRF_SEL;
  localparam int REG_SEL  = 5;
  localparam int INSN_LEN = 32;
  localparam int COMNUM_W = 3;
endpackage

`ifndef ROB_LANE
`define ROB_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - prefix-AND of valid&finished over CM_W entries from the commit pointer
module rob_commit_sel
  import rob_nway_pkg::*;
#(
  parameter int ROB_SEL = rob_nway_pkg::ROB_SEL,
  parameter int CM_W    = 2
) (
  input  logic [2**ROB_SEL-1:0] valid_i,
  input  logic [2**ROB_SEL-1:0] fin_i,
  input  logic [ROB_SEL-1:0]    ptr_i,
  output logic [CM_W-1:0]       elig_o,
  output logic [COMNUM_W-1:0]   comnum_o
);

  logic               w_run;
  logic [ROB_SEL-1:0] w_tag;

  // A lane is eligible only while every older lane in the run is also ready.
  always_comb begin
    elig_o   = '0;
    comnum_o = '0;
    w_run    = 1'b1;
    w_tag    = ptr_i;
    for (int k = 0; k < CM_W; k++) begin
      w_tag     = ptr_i + ROB_SEL'(k);
      w_run     = w_run & valid_i[w_tag] & fin_i[w_tag];
      elig_o[k] = w_run;
      if (w_run) comnum_o = comnum_o + COMNUM_W'(1);
    end
  end

endmodule

// File: rtl/rob_nway.sv
// rtl/rob_nway.sv - tag-indexed reorder buffer, DP_W dispatch / FIN_N finish / CM_W in-order commit
// Optional ROB_FLUSH_EN adds flush_i, which discards every in-flight entry.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter int ROB_SEL  = rob_nway_pkg::ROB_SEL,
  parameter int DP_W     = 2,
  parameter int CM_W     = 2,
  parameter int FIN_N    = 4,
  parameter int REG_SEL  = rob_nway_pkg::REG_SEL,
  parameter int INSN_LEN = rob_nway_pkg::INSN_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef ROB_FLUSH_EN
  input  logic                     flush_i,
`endif
  input  logic [DP_W-1:0]          dp_i,
  input  logic [DP_W*ROB_SEL-1:0]  dp_addr_i,
  input  logic [DP_W*INSN_LEN-1:0] pc_dp_i,
  input  logic [DP_W-1:0]          dstvalid_dp_i,
  input  logic [DP_W*REG_SEL-1:0]  dst_dp_i,
  input  logic [FIN_N-1:0]         finish_i,
  input  logic [FIN_N*ROB_SEL-1:0] finish_addr_i,
  output logic [ROB_SEL-1:0]       commit_ptr_o,
  output logic [COMNUM_W-1:0]      comnum_o,
  output logic [CM_W-1:0]          arfwe_o,
  output logic [CM_W*REG_SEL-1:0]  dst_arf_o,
  output logic [CM_W*ROB_SEL-1:0]  com_tag_o,
  output logic [CM_W*INSN_LEN-1:0] com_pc_o,
  output logic [ROB_SEL:0]         occupancy_o
);

  localparam int DEPTH = 2**ROB_SEL;

  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_fin;
  logic [DEPTH-1:0]    r_dstv;
  logic [REG_SEL-1:0]  r_dst [DEPTH];
  logic [INSN_LEN-1:0] r_pc  [DEPTH];
  logic [ROB_SEL-1:0]  r_ptr;
  logic [ROB_SEL:0]    r_occ;

  logic                w_flush;
  logic [CM_W-1:0]     w_elig;
  logic [CM_W-1:0]     w_commit;
  logic [COMNUM_W-1:0] w_comnum_raw;
  logic [COMNUM_W-1:0] w_comnum;
  logic [ROB_SEL:0]    w_dpcnt;
  logic [ROB_SEL-1:0]  w_ctag;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  rob_commit_sel #(
    .ROB_SEL (ROB_SEL),
    .CM_W    (CM_W)
  ) u_commit_sel (
    .valid_i  (r_valid),
    .fin_i    (r_fin),
    .ptr_i    (r_ptr),
    .elig_o   (w_elig),
    .comnum_o (w_comnum_raw)
  );

  assign w_commit = w_flush ? '0 : w_elig;
  assign w_comnum = w_flush ? '0 : w_comnum_raw;

  always_comb begin
    w_dpcnt = '0;
    for (int k = 0; k < DP_W; k++) w_dpcnt = w_dpcnt + (ROB_SEL+1)'(dp_i[k]);
  end

  // Lanes that do not commit present all-zero payload.
  always_comb begin
    arfwe_o   = '0;
    dst_arf_o = '0;
    com_tag_o = '0;
    com_pc_o  = '0;
    w_ctag    = r_ptr;
    for (int k = 0; k < CM_W; k++) begin
      w_ctag = r_ptr + ROB_SEL'(k);
      if (w_commit[k]) begin
        arfwe_o[k]                       = r_dstv[w_ctag];
        `ROB_LANE(dst_arf_o, k, REG_SEL) = r_dst[w_ctag];
        `ROB_LANE(com_tag_o, k, ROB_SEL) = w_ctag;
        `ROB_LANE(com_pc_o, k, INSN_LEN) = r_pc[w_ctag];
      end
    end
  end

  assign commit_ptr_o = r_ptr;
  assign comnum_o     = w_comnum;
  assign occupancy_o  = r_occ;

  // Statement order sets priority: dispatch over commit-clear over finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_fin   <= '0;
      r_ptr   <= '0;
      r_occ   <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
      r_fin   <= '0;
      r_occ   <= '0;
    end else begin
      for (int j = 0; j < FIN_N; j++) begin
        if (finish_i[j] && r_valid[`ROB_LANE(finish_addr_i, j, ROB_SEL)])
          r_fin[`ROB_LANE(finish_addr_i, j, ROB_SEL)] <= 1'b1;
      end
      for (int k = 0; k < CM_W; k++) begin
        if (w_elig[k]) begin
          r_valid[r_ptr + ROB_SEL'(k)] <= 1'b0;
          r_fin[r_ptr + ROB_SEL'(k)]   <= 1'b0;
        end
      end
      for (int k = 0; k < DP_W; k++) begin
        if (dp_i[k]) begin
          r_valid[`ROB_LANE(dp_addr_i, k, ROB_SEL)] <= 1'b1;
          r_fin[`ROB_LANE(dp_addr_i, k, ROB_SEL)]   <= 1'b0;
          r_dstv[`ROB_LANE(dp_addr_i, k, ROB_SEL)]  <= dstvalid_dp_i[k];
          r_dst[`ROB_LANE(dp_addr_i, k, ROB_SEL)]   <= `ROB_LANE(dst_dp_i, k, REG_SEL);
          r_pc[`ROB_LANE(dp_addr_i, k, ROB_SEL)]    <= `ROB_LANE(pc_dp_i, k, INSN_LEN);
        end
      end
      r_ptr <= r_ptr + ROB_SEL'(w_comnum);
      r_occ <= r_occ + w_dpcnt - (ROB_SEL+1)'(w_comnum);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !((r_occ == (ROB_SEL+1)'(DEPTH)) && (|dp_i)));
`endif

endmodule

// File: doc/rob_nway.md
Name: rob_nway

Overview:
- Parametrised reorder buffer; next generation of the single-dispatch, single-commit ROB.
- Indexed by RRF tag. Accepts up to DP_W dispatches and FIN_N execution-finish reports per cycle.
- Retires up to CM_W oldest consecutive finished entries per cycle, in program order.
- Sits between dispatch/rename and the ARF/RRF commit path.

Parameters:
- ROB_SEL, 6, entry-index width; depth = 2**ROB_SEL; equals RRF_SEL.
- DP_W, 2, dispatch lanes (1..4).
- CM_W, 2, commit lanes (1..4).
- FIN_N, 4, finish ports (ALU/MUL/BRANCH/LDST).
- REG_SEL, 5, architectural register index width.
- INSN_LEN, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dp_i  in  DP_W  per-lane dispatch valid
- dp_addr_i  in  DP_W*ROB_SEL  per-lane entry tag (lane k in bits [k*ROB_SEL +: ROB_SEL])
- pc_dp_i  in  DP_W*INSN_LEN  per-lane PC
- dstvalid_dp_i  in  DP_W  lane writes a destination register
- dst_dp_i  in  DP_W*REG_SEL  per-lane architectural destination
- finish_i  in  FIN_N  per-port finish valid
- finish_addr_i  in  FIN_N*ROB_SEL  per-port finished tag
- commit_ptr_o  out  ROB_SEL  oldest uncommitted tag
- comnum_o  out  3  entries committed this cycle (0..CM_W)
- arfwe_o  out  CM_W  per-lane ARF write enable
- dst_arf_o  out  CM_W*REG_SEL  per-lane ARF destination
- com_tag_o  out  CM_W*ROB_SEL  per-lane committed tag (commit_ptr+k)
- com_pc_o  out  CM_W*INSN_LEN  per-lane committed PC
- occupancy_o  out  ROB_SEL+1  valid-entry count
- flush_i  in  1  present only with ROB_FLUSH_EN

Behaviour:
- Per-entry state: valid, finished, dstvalid, dst, pc. Updates are registered on the clk rising edge.
- Reset (reset=1 at the edge):
  - all valid/finished cleared; commit_ptr_o=0; occupancy_o=0.
  - Every commit output reads 0; they are combinational from state, gated by commit.
  - Reset mid-operation discards all entries.
- Dispatch lane k with dp_i[k]=1: entry[tag] gets valid=1, finished=0, dst, dstvalid, pc.
  - Tags must be consecutive from the allocation tail. This is the allocator's obligation and is not checked.
- Finish port j: sets finished on entry[finish_addr]. The effect is visible to commit logic one cycle later.
  - Ignored if that entry is invalid.
  - Duplicate tags across ports are harmless.
- Commit lane k is eligible iff entries commit_ptr+0..k, mod depth, are all valid and finished. Lane k is never eligible if lane k-1 is not.
  - comnum_o = number of eligible lanes.
  - arfwe_o[k] = eligible & dstvalid.
  - Next cycle: committed entries have valid cleared; commit_ptr += comnum_o (wraps mod 2**ROB_SEL).
- Simultaneous events on the same entry in one cycle:
  - dispatch vs finish: dispatch wins, finished=0.
  - commit-clear vs dispatch: dispatch wins, entry valid.
  - commit-clear vs finish: clear wins.
- occupancy_o_next = occupancy + popcount(dp_i) - comnum_o.
  - Full (occupancy = depth) with a dispatch is an upstream violation.
  - The optional simulation assertion fires on it.
- Empty buffer: comnum_o=0, all arfwe_o=0, commit_ptr_o holds.
- Wrap-around: eligibility and tag arithmetic are modulo depth. A commit run may span tag depth-1 to 0.

Optional Feature:
- Macro: ROB_FLUSH_EN.
- Defined: the flush_i port exists. flush_i=1 clears every valid/finished bit and sets occupancy to 0 at the edge.
  - commit_ptr_o holds; the allocator restarts there.
  - Commit outputs are forced 0 in the flush cycle.
  - flush_i takes priority over same-cycle dispatch, finish and commit.
- Undefined: no flush_i port. Entries are cleared only by commit or reset.

Decomposition:
- Shared package/consts header holds RRF_SEL, ROB_SEL, REG_SEL, INSN_LEN and the lane-slice helper macro.
- One sub-module, rob_commit_sel: combinational prefix-AND of valid&finished over CM_W entries from commit_ptr. Outputs the eligibility vector and comnum.

Test Plan:
- Reset then idle:
  - reset=1 for 2 cycles -> commit_ptr_o=0, comnum_o=0, arfwe_o=0, occupancy_o=0.
- Dual dispatch, out-of-order finish:
  - dispatch tags 0,1 (dst 3,4, dstvalid 1,1); finish tag1 at cycle t, tag0 at t+2.
  - -> nothing commits before t+3; at t+3 comnum_o=2, dst_arf_o={4,3}, arfwe_o=2'b11; then commit_ptr_o=2.
- Gap stall:
  - tags 0..3 dispatched; tags 0,2,3 finished -> comnum_o=1 (tag0 only).
  - After tag1 finishes -> comnum_o=2 next cycle, then 1 the cycle after.
- Wrap-around:
  - advance commit_ptr to 62; dispatch and finish tags 62,63,0 -> commits 62,63, then 0; commit_ptr_o=1.
- dstvalid=0 and collisions:
  - tag 5 with dstvalid=0 commits with arfwe_o lane=0, comnum_o counts it.
  - finish to an invalid tag -> no state change.
  - dispatch+finish same tag same cycle -> finished stays 0.
- Flush (ROB_FLUSH_EN):
  - 3 valid entries, flush_i with a same-cycle finish -> occupancy_o=0, comnum_o=0 next cycle, commit_ptr_o unchanged.
